// File: rtl/fpu_ss_writeback_if.sv
// Bundle of issue, operand-lookup, result-stream and regfile-write signals
// exchanged with the FPU subsystem write-back stage.
interface fpu_ss_writeback_if #(
    parameter int unsigned NumRegs = 32
);
    localparam int unsigned AddrW = $clog2(NumRegs);

    logic                      issue_valid_i;
    logic [AddrW-1:0]          issue_rd_i;
    logic                      issue_ready_o;

    logic [2:0][AddrW-1:0]     rs_addr_i;
    logic [2:0]                rs_busy_o;

    logic                      fpu_valid_i;
    logic [AddrW-1:0]          fpu_rd_i;
    logic [31:0]               fpu_data_i;
    logic                      fpu_ready_o;

    logic                      mem_valid_i;
    logic [AddrW-1:0]          mem_rd_i;
    logic [31:0]               mem_data_i;
    logic                      mem_ready_o;

    logic                      rf_we_o;
    logic [AddrW-1:0]          rf_waddr_o;
    logic [31:0]               rf_wdata_o;

    logic [NumRegs-1:0]        scoreboard_o;
    logic                      wb_spurious_o;

    // Write-back stage side.
    modport slave (
        input  issue_valid_i, issue_rd_i, rs_addr_i,
        input  fpu_valid_i, fpu_rd_i, fpu_data_i,
        input  mem_valid_i, mem_rd_i, mem_data_i,
        output issue_ready_o, rs_busy_o, fpu_ready_o, mem_ready_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o, scoreboard_o, wb_spurious_o
    );

    // Surrounding pipeline side.
    modport master (
        output issue_valid_i, issue_rd_i, rs_addr_i,
        output fpu_valid_i, fpu_rd_i, fpu_data_i,
        output mem_valid_i, mem_rd_i, mem_data_i,
        input  issue_ready_o, rs_busy_o, fpu_ready_o, mem_ready_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o, scoreboard_o, wb_spurious_o
    );
endinterface

// File: rtl/fpu_ss_writeback.sv
// FPU subsystem write-back stage: arbitrates FPU vs. load results onto the
// single regfile write port and tracks pending destinations in a scoreboard.
module fpu_ss_writeback #(
    parameter int unsigned NumRegs     = 32,
    parameter int unsigned StarveLimit = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fpu_ss_writeback_if.slave  wb
);
    localparam int unsigned AddrW = $clog2(NumRegs);

    logic [3:0]         starve_q, starve_d;
    logic               rf_we_q, rf_we_d;
    logic [AddrW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [31:0]        rf_wdata_q, rf_wdata_d;
    logic [NumRegs-1:0] sb_q, sb_d;
    logic               spurious_q, spurious_d;

    logic               fpu_gnt, mem_gnt, xfer, issue_ready;
    logic [AddrW-1:0]   xfer_rd;
    logic [31:0]        xfer_data;
    logic [2:0]         rs_busy;

    // FPU has priority unless the load stream has lost too many times in a row.
    always_comb begin
        fpu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (!rst_i) begin
            if (wb.fpu_valid_i && wb.mem_valid_i) begin
                if (starve_q >= 4'(StarveLimit)) mem_gnt = 1'b1;
                else                             fpu_gnt = 1'b1;
            end else begin
                fpu_gnt = wb.fpu_valid_i;
                mem_gnt = wb.mem_valid_i;
            end
        end
        xfer      = fpu_gnt | mem_gnt;
        xfer_rd   = mem_gnt ? wb.mem_rd_i   : wb.fpu_rd_i;
        xfer_data = mem_gnt ? wb.mem_data_i : wb.fpu_data_i;
    end

    always_comb begin
        starve_d = starve_q;
        if (rst_i) begin
            starve_d = '0;
        end else if (mem_gnt) begin
            starve_d = '0;
        end else if (wb.mem_valid_i && starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_comb begin
        rf_we_d    = xfer;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        spurious_d = xfer & ~sb_q[xfer_rd];
        if (xfer) begin
            rf_waddr_d = xfer_rd;
            rf_wdata_d = xfer_data;
        end
        if (rst_i) begin
            rf_we_d    = 1'b0;
            rf_waddr_d = '0;
            rf_wdata_d = '0;
            spurious_d = 1'b0;
        end
    end

    // Clear applied before set so a same-index allocation survives the commit.
    always_comb begin
        issue_ready = ~rst_i & wb.issue_valid_i & ~sb_q[wb.issue_rd_i];
        sb_d        = sb_q;
        if (rf_we_q)     sb_d[rf_waddr_q]    = 1'b0;
        if (issue_ready) sb_d[wb.issue_rd_i] = 1'b1;
        if (rst_i)       sb_d                = '0;
    end

    always_comb begin
        rs_busy = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            rs_busy[i] = sb_q[wb.rs_addr_i[i]];
        end
    end

    always_ff @(posedge clk_i) begin
        starve_q   <= starve_d;
        rf_we_q    <= rf_we_d;
        rf_waddr_q <= rf_waddr_d;
        rf_wdata_q <= rf_wdata_d;
        sb_q       <= sb_d;
        spurious_q <= spurious_d;
    end

    assign wb.issue_ready_o = issue_ready;
    assign wb.rs_busy_o     = rs_busy;
    assign wb.fpu_ready_o   = fpu_gnt;
    assign wb.mem_ready_o   = mem_gnt;
    assign wb.rf_we_o       = rf_we_q;
    assign wb.rf_waddr_o    = rf_waddr_q;
    assign wb.rf_wdata_o    = rf_wdata_q;
    assign wb.scoreboard_o  = sb_q;
    assign wb.wb_spurious_o = spurious_q;

endmodule

// File: tb/tb_fpu_ss_writeback.sv
// Directed bench for fpu_ss_writeback: reset, single write, starvation,
// WAW stall, set/clear collision, spurious write-back and mid-run reset.
module tb_fpu_ss_writeback;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fpu_ss_writeback_if #(.NumRegs(32)) wb_if ();

    fpu_ss_writeback #(.NumRegs(32), .StarveLimit(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (wb_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let registered outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wb_if.issue_valid_i = 1'b0;
        wb_if.issue_rd_i    = '0;
        wb_if.rs_addr_i     = '0;
        wb_if.fpu_valid_i   = 1'b1;
        wb_if.fpu_rd_i      = '0;
        wb_if.fpu_data_i    = '0;
        wb_if.mem_valid_i   = 1'b0;
        wb_if.mem_rd_i      = '0;
        wb_if.mem_data_i    = '0;

        // Reset held for two edges with FPU valid.
        step();
        step();
        check("rst_fpu_ready", 32'(wb_if.fpu_ready_o), 32'd0);
        check("rst_rf_we", 32'(wb_if.rf_we_o), 32'd0);
        check("rst_waddr", 32'(wb_if.rf_waddr_o), 32'd0);
        check("rst_wdata", wb_if.rf_wdata_o, 32'd0);
        check("rst_sb", wb_if.scoreboard_o, 32'd0);
        check("rst_spurious", 32'(wb_if.wb_spurious_o), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_fpu_ready", 32'(wb_if.fpu_ready_o), 32'd1);
        wb_if.fpu_valid_i = 1'b0;

        // Single FPU write to f5.
        wb_if.issue_valid_i = 1'b1;
        wb_if.issue_rd_i    = 5'd5;
        wb_if.rs_addr_i[0]  = 5'd5;
        #1;
        check("issue5_ready", 32'(wb_if.issue_ready_o), 32'd1);
        step();
        wb_if.issue_valid_i = 1'b0;
        check("c1_sb", wb_if.scoreboard_o, 32'h0000_0020);
        check("c1_busy", 32'(wb_if.rs_busy_o), 32'd1);
        step();
        check("c2_sb5", 32'(wb_if.scoreboard_o[5]), 32'd1);
        step();
        wb_if.fpu_valid_i = 1'b1;
        wb_if.fpu_rd_i    = 5'd5;
        wb_if.fpu_data_i  = 32'h3F80_0000;
        #1;
        check("c3_fpu_ready", 32'(wb_if.fpu_ready_o), 32'd1);
        check("c3_sb5", 32'(wb_if.scoreboard_o[5]), 32'd1);
        step();
        wb_if.fpu_valid_i = 1'b0;
        check("c4_we", 32'(wb_if.rf_we_o), 32'd1);
        check("c4_waddr", 32'(wb_if.rf_waddr_o), 32'd5);
        check("c4_wdata", wb_if.rf_wdata_o, 32'h3F80_0000);
        check("c4_sb5", 32'(wb_if.scoreboard_o[5]), 32'd1);
        check("c4_busy", 32'(wb_if.rs_busy_o), 32'd1);
        check("c4_spurious", 32'(wb_if.wb_spurious_o), 32'd0);
        step();
        check("c5_sb", wb_if.scoreboard_o, 32'd0);
        check("c5_busy", 32'(wb_if.rs_busy_o), 32'd0);
        check("c5_we", 32'(wb_if.rf_we_o), 32'd0);
        check("c5_waddr_hold", 32'(wb_if.rf_waddr_o), 32'd5);
        check("c5_wdata_hold", wb_if.rf_wdata_o, 32'h3F80_0000);

        // Both sources valid: F,F,F,F,M repeating.
        wb_if.fpu_valid_i = 1'b1;
        wb_if.fpu_rd_i    = 5'd1;
        wb_if.fpu_data_i  = 32'h1111_1111;
        wb_if.mem_valid_i = 1'b1;
        wb_if.mem_rd_i    = 5'd2;
        wb_if.mem_data_i  = 32'h2222_2222;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("starve_fpu_rdy%0d", i), 32'(wb_if.fpu_ready_o), (i % 5 == 4) ? 32'd0 : 32'd1);
            check($sformatf("starve_mem_rdy%0d", i), 32'(wb_if.mem_ready_o), (i % 5 == 4) ? 32'd1 : 32'd0);
            step();
            check($sformatf("starve_waddr%0d", i), 32'(wb_if.rf_waddr_o), (i % 5 == 4) ? 32'd2 : 32'd1);
        end
        wb_if.fpu_valid_i = 1'b0;
        wb_if.mem_valid_i = 1'b0;
        step();

        // WAW stall on f7 while f8 is accepted.
        wb_if.issue_valid_i = 1'b1;
        wb_if.issue_rd_i    = 5'd7;
        #1;
        check("waw_first7", 32'(wb_if.issue_ready_o), 32'd1);
        step();
        check("waw_stall7", 32'(wb_if.issue_ready_o), 32'd0);
        wb_if.issue_rd_i = 5'd8;
        #1;
        check("waw_accept8", 32'(wb_if.issue_ready_o), 32'd1);
        step();
        wb_if.issue_rd_i  = 5'd7;
        wb_if.fpu_valid_i = 1'b1;
        wb_if.fpu_rd_i    = 5'd7;
        wb_if.fpu_data_i  = 32'h4000_0000;
        #1;
        check("waw_stall7_b", 32'(wb_if.issue_ready_o), 32'd0);
        step();
        wb_if.fpu_valid_i = 1'b0;
        check("waw_we7", 32'(wb_if.rf_we_o), 32'd1);
        check("waw_stall7_c", 32'(wb_if.issue_ready_o), 32'd0);
        step();
        check("waw_release7", 32'(wb_if.issue_ready_o), 32'd1);
        check("waw_sb", wb_if.scoreboard_o, 32'h0000_0100);
        step();
        wb_if.issue_valid_i = 1'b0;
        check("waw_realloc", wb_if.scoreboard_o, 32'h0000_0180);

        // Same-index collision: spurious write to f9 lands as f9 is allocated.
        wb_if.mem_valid_i = 1'b1;
        wb_if.mem_rd_i    = 5'd9;
        wb_if.mem_data_i  = 32'h0909_0909;
        step();
        wb_if.mem_valid_i   = 1'b0;
        wb_if.issue_valid_i = 1'b1;
        wb_if.issue_rd_i    = 5'd9;
        #1;
        check("col_we9", 32'(wb_if.rf_we_o), 32'd1);
        check("col_issue9", 32'(wb_if.issue_ready_o), 32'd1);
        step();
        wb_if.issue_valid_i = 1'b0;
        check("col_sb9_set", 32'(wb_if.scoreboard_o[9]), 32'd1);

        // Different indices: clear f9 while allocating f10.
        wb_if.fpu_valid_i = 1'b1;
        wb_if.fpu_rd_i    = 5'd9;
        wb_if.fpu_data_i  = 32'h9999_0000;
        step();
        wb_if.fpu_valid_i   = 1'b0;
        wb_if.issue_valid_i = 1'b1;
        wb_if.issue_rd_i    = 5'd10;
        step();
        wb_if.issue_valid_i = 1'b0;
        check("diff_sb9", 32'(wb_if.scoreboard_o[9]), 32'd0);
        check("diff_sb10", 32'(wb_if.scoreboard_o[10]), 32'd1);
        check("diff_sb", wb_if.scoreboard_o, 32'h0000_0580);

        // Spurious load write-back to f12.
        wb_if.mem_valid_i = 1'b1;
        wb_if.mem_rd_i    = 5'd12;
        wb_if.mem_data_i  = 32'hDEAD_BEEF;
        #1;
        check("spur_mem_ready", 32'(wb_if.mem_ready_o), 32'd1);
        step();
        wb_if.mem_valid_i = 1'b0;
        check("spur_pulse", 32'(wb_if.wb_spurious_o), 32'd1);
        check("spur_we", 32'(wb_if.rf_we_o), 32'd1);
        check("spur_waddr", 32'(wb_if.rf_waddr_o), 32'd12);
        check("spur_wdata", wb_if.rf_wdata_o, 32'hDEAD_BEEF);
        step();
        check("spur_pulse_end", 32'(wb_if.wb_spurious_o), 32'd0);
        check("spur_we_end", 32'(wb_if.rf_we_o), 32'd0);

        // Reset mid-operation drops the registered write and pending entries.
        wb_if.fpu_valid_i = 1'b1;
        wb_if.fpu_rd_i    = 5'd3;
        wb_if.fpu_data_i  = 32'h3333_3333;
        step();
        wb_if.fpu_valid_i = 1'b0;
        check("mid_we_before", 32'(wb_if.rf_we_o), 32'd1);
        rst = 1'b1;
        wb_if.mem_valid_i = 1'b1;
        #1;
        check("mid_mem_ready", 32'(wb_if.mem_ready_o), 32'd0);
        step();
        wb_if.mem_valid_i = 1'b0;
        check("mid_we", 32'(wb_if.rf_we_o), 32'd0);
        check("mid_sb", wb_if.scoreboard_o, 32'd0);
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_ss_writeback.md
Name: fpu_ss_writeback

Overview:
Write-back stage directly upstream of the FPU subsystem register file (32 x 32-bit, 3 read ports, 1 write port, no reset, writes on clock edge when we asserted).
- Arbitrates between FPU result stream and memory-load (FLW) result stream; registers the winner onto the single regfile write port.
- Holds a 32-entry scoreboard of pending destination registers; supplies operand-busy and issue-stall information to the issue logic.

Parameters:
NumRegs, 32, number of FP registers / scoreboard bits (address width = $clog2(NumRegs) = 5).
StarveLimit, 4, consecutive lost arbitrations after which the memory source wins over the FPU (range 1..15).

Ports:
clk_i  input  1  clock, all state updates on rising edge.
rst_i  input  1  synchronous active-high reset.
issue_valid_i  input  1  issue stage requests allocation of a destination register.
issue_rd_i  input  5  destination register of the issuing instruction.
issue_ready_o  output  1  allocation accepted this cycle.
rs_addr_i  input  3x5  source operand addresses (same ordering as regfile read ports).
rs_busy_o  output  3  per-operand pending-write flag.
fpu_valid_i  input  1  FPU result valid.
fpu_rd_i  input  5  FPU result destination.
fpu_data_i  input  32  FPU result data.
fpu_ready_o  output  1  FPU result accepted this cycle.
mem_valid_i  input  1  load result valid.
mem_rd_i  input  5  load destination.
mem_data_i  input  32  load data.
mem_ready_o  output  1  load result accepted this cycle.
rf_we_o  output  1  regfile write enable (registered).
rf_waddr_o  output  5  regfile write address (registered).
rf_wdata_o  output  32  regfile write data (registered).
scoreboard_o  output  32  current scoreboard bit vector.
wb_spurious_o  output  1  one-cycle pulse: write-back to register whose scoreboard bit was clear.

Behaviour:
- Reset (rst_i=1 at clock edge): scoreboard=0, starvation counter=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, wb_spurious_o=0. Reset mid-operation drops any registered write (rf_we_o low next cycle) and all pending entries; ready outputs are 0 while rst_i=1.
- Arbitration (combinational, one grant per cycle):
  - only one source valid: that source granted.
  - both valid: FPU granted unless starve_cnt >= StarveLimit, then memory granted.
  - fpu_ready_o = FPU grant; mem_ready_o = memory grant. Ready never asserted without matching valid. Transfer = valid & ready in same cycle.
- starve_cnt (4 bits): +1 when mem_valid_i=1 and memory not granted; cleared when memory granted; held otherwise; saturates at 15.
- Write register: on transfer in cycle N, rf_we_o/rf_waddr_o/rf_wdata_o reflect the granted source in cycle N+1; rf_we_o=0 in any cycle following a cycle with no transfer. Regfile always accepts, so no back-pressure; sustained throughput 1 write/cycle. rf_waddr_o/rf_wdata_o hold last value when rf_we_o=0.
- Scoreboard:
  - issue_ready_o = issue_valid_i & ~scoreboard[issue_rd_i] (WAW stall).
  - set scoreboard[issue_rd_i] at edge when issue_valid_i & issue_ready_o.
  - clear scoreboard[rf_waddr_o] at the edge where rf_we_o=1 (same edge regfile commits data). Busy therefore drops in cycle N+2 after transfer in N, when regfile already holds the new value; no bypass.
  - simultaneous set and clear of same index: set wins (clear then new allocation). Different indices: both applied.
  - rs_busy_o[i] = scoreboard[rs_addr_i[i]], combinational.
  - scoreboard_o = scoreboard register.
- wb_spurious_o: registered, high in cycle N+1 if the transfer in N targets an index whose scoreboard bit was 0 in cycle N; write still performed.
- Register 0 is an ordinary FP register (f0), tracked and written normally.

Test Plan:
- Reset: hold rst_i 2 cycles with fpu_valid_i=1 -> fpu_ready_o=0, rf_we_o=0, scoreboard_o=0; first cycle after release fpu_ready_o=1.
- Single FPU write: issue rd=5 in cycle 0, fpu_valid_i rd=5 data=0x3F800000 in cycle 3 -> fpu_ready_o=1 cycle 3, rf_we_o=1/rf_waddr_o=5/rf_wdata_o=0x3F800000 cycle 4, scoreboard_o[5]=1 cycles 1..4, 0 from cycle 5; rs_busy_o tracks it.
- Starvation: both sources continuously valid, StarveLimit=4 -> grant pattern FPU,FPU,FPU,FPU,MEM repeating; starve_cnt returns to 0 after each MEM grant.
- WAW stall: rd=7 pending, issue_valid_i rd=7 -> issue_ready_o=0 until cycle after rf_we_o writes 7; issue rd=8 same time -> accepted.
- Set/clear collision: rf_we_o writing rd=9 while issuing rd=9 (issue allowed only if bit already cleared — force via second allocation after wb edge) -> scoreboard_o[9]=1 afterwards; different indices 9/10 -> bit 9 cleared, bit 10 set.
- Spurious write: mem_valid_i rd=12 with scoreboard_o[12]=0 -> wb_spurious_o=1 for one cycle, rf_we_o=1 to address 12 with given data.
